// File: rtl/ahb_apb_bridge_mslv_if.sv
// ahb_apb_bridge_mslv_if
// Bundles the AHB-Lite slave port and the multi-slave APB4 master port of the bridge.
//   slave  modport : the bridge's view (AHB request in, AHB response out,
//                    APB request out, APB response in).
//   master modport : the environment's view (AHB master plus the APB slaves).
// Signals:
//   HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA  AHB address and data phase
//   HRDATA/HREADY/HRESP                    AHB response
//   PADDR/PWDATA/PWRITE/PSTRB/PENABLE/PSEL APB request, PSEL one-hot per slave
//   PRDATA/PREADY/PSLVERR                  per-slave APB response, slave i at slice i
interface ahb_apb_bridge_mslv_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SLV = 4
);
    logic                      HSEL;
    logic [ADDR_W-1:0]         HADDR;
    logic [1:0]                HTRANS;
    logic                      HWRITE;
    logic [2:0]                HSIZE;
    logic [DATA_W-1:0]         HWDATA;
    logic [DATA_W-1:0]         HRDATA;
    logic                      HREADY;
    logic                      HRESP;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic                      PWRITE;
    logic [DATA_W/8-1:0]       PSTRB;
    logic                      PENABLE;
    logic [NUM_SLV-1:0]        PSEL;
    logic [NUM_SLV*DATA_W-1:0] PRDATA;
    logic [NUM_SLV-1:0]        PREADY;
    logic [NUM_SLV-1:0]        PSLVERR;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, PRDATA, PREADY, PSLVERR,
        output HRDATA, HREADY, HRESP, PADDR, PWDATA, PWRITE, PSTRB, PENABLE, PSEL
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, PRDATA, PREADY, PSLVERR,
        input  HRDATA, HREADY, HRESP, PADDR, PWDATA, PWRITE, PSTRB, PENABLE, PSEL
    );
endinterface

// File: rtl/ahb_apb_bridge_mslv.sv
// ahb_apb_bridge_mslv
// AHB-Lite slave to APB4 master bridge fanning out to NUM_SLV one-hot selected APB slaves.
// Decode errors (slave index out of range, oversize transfer), PSLVERR and the PREADY
// watchdog all end in a two-cycle AHB ERROR response. All outputs are registered.
// Ports:
//   HCLK    clock, rising edge
//   HRESET  asynchronous active-high reset
//   bus     ahb_apb_bridge_mslv_if.slave: AHB slave port plus APB master port
module ahb_apb_bridge_mslv #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned SLV_LSB = 12,
    parameter int unsigned TIMEOUT = 16
) (
    input logic                  HCLK,
    input logic                  HRESET,
    ahb_apb_bridge_mslv_if.slave bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle, StWdata, StSetup, StAccess, StDone, StErr1, StErr2
    } state_e;

    state_e              state_q, state_d;
    logic                hready_q, hready_d;
    logic                hresp_q, hresp_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic                penable_q, penable_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept;
    logic [ADDR_W-1:0]   haddr_hi;
    logic                idx_err;
    logic                size_err;
    logic [SEL_W-1:0]    req_idx;
    logic [NUM_SLV-1:0]  req_sel;
    logic [NUM_SLV-1:0]  idx_sel;
    logic [STRB_W-1:0]   req_strb;
    int unsigned         nbytes;
    int unsigned         base;

    assign accept   = bus.HSEL & bus.HTRANS[1] & hready_q;
    // Everything above the slave field counts toward the index, so addresses beyond the
    // last slave window fault instead of aliasing onto a lower slave.
    assign haddr_hi = bus.HADDR >> SLV_LSB;
    assign idx_err  = (haddr_hi >= ADDR_W'(NUM_SLV));
    assign size_err = (32'(bus.HSIZE) > OFF_W);
    assign req_idx  = bus.HADDR[SLV_LSB +: SEL_W];

    always_comb begin
        req_sel          = '0;
        req_sel[req_idx] = 1'b1;
        idx_sel          = '0;
        idx_sel[idx_q]   = 1'b1;
    end

    // Byte lanes covered by the transfer; low address bits below the size are dropped.
    always_comb begin
        req_strb = '0;
        nbytes   = 32'd1 << bus.HSIZE;
        base     = 32'(bus.HADDR[OFF_W-1:0]) & ~(nbytes - 32'd1);
        for (int unsigned b = 0; b < STRB_W; b++) begin
            req_strb[b] = (b >= base) && (b < base + nbytes);
        end
    end

    always_comb begin
        state_d   = state_q;
        hready_d  = hready_q;
        hresp_d   = hresp_q;
        hrdata_d  = hrdata_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        pstrb_d   = pstrb_q;
        penable_d = penable_q;
        psel_d    = psel_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            // Every state with HREADY high can take the next address phase.
            StIdle, StDone, StErr2: begin
                state_d  = StIdle;
                hready_d = 1'b1;
                hresp_d  = 1'b0;
                if (accept) begin
                    hready_d = 1'b0;
                    if (idx_err || size_err) begin
                        state_d = StErr1;
                        hresp_d = 1'b1;
                    end else begin
                        idx_d    = req_idx;
                        paddr_d  = bus.HADDR;
                        pwrite_d = bus.HWRITE;
                        pstrb_d  = bus.HWRITE ? req_strb : '0;
                        if (bus.HWRITE) begin
                            state_d = StWdata;
                        end else begin
                            state_d = StSetup;
                            psel_d  = req_sel;
                        end
                    end
                end
            end
            StWdata: begin
                pwdata_d = bus.HWDATA;
                psel_d   = idx_sel;
                state_d  = StSetup;
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = CNT_W'(1);
                state_d   = StAccess;
            end
            StAccess: begin
                if (bus.PREADY[idx_q]) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    if (bus.PSLVERR[idx_q]) begin
                        state_d = StErr1;
                        hresp_d = 1'b1;
                    end else begin
                        state_d  = StDone;
                        hready_d = 1'b1;
                        if (!pwrite_q) begin
                            hrdata_d = bus.PRDATA[32'(idx_q) * DATA_W +: DATA_W];
                        end
                    end
                end else if ((TIMEOUT != 0) && (32'(cnt_q) >= TIMEOUT)) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StErr1;
                    hresp_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StErr1: begin
                state_d  = StErr2;
                hready_d = 1'b1;
                hresp_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= StIdle;
            hready_q  <= 1'b1;
            hresp_q   <= 1'b0;
            hrdata_q  <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            pstrb_q   <= '0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            hrdata_q  <= hrdata_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            pstrb_q   <= pstrb_d;
            penable_q <= penable_d;
            psel_q    <= psel_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.HREADY  = hready_q;
    assign bus.HRESP   = hresp_q;
    assign bus.HRDATA  = hrdata_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PSTRB   = pstrb_q;
    assign bus.PENABLE = penable_q;
    assign bus.PSEL    = psel_q;
endmodule

// File: tb/tb_ahb_apb_bridge_mslv.sv
// Bench for ahb_apb_bridge_mslv: directed AHB transfers, expected APB setups and AHB
// responses queued at issue time, checked by an independent negedge monitor.
module tb_ahb_apb_bridge_mslv;
    logic clk;
    logic rst;

    ahb_apb_bridge_mslv_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();

    ahb_apb_bridge_mslv #(
        .ADDR_W (32),
        .DATA_W (32),
        .NUM_SLV(4),
        .SLV_LSB(12),
        .TIMEOUT(16)
    ) dut (
        .HCLK  (clk),
        .HRESET(rst),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // APB slave model: selected slave waits slv_wait ACCESS cycles; others look ready+error.
    localparam logic [31:0] SLV_DATA [4] = '{32'h1111_0000, 32'h2222_1111, 32'hCAFE_F00D,
                                             32'h4444_3333};
    int   slv_wait  = 0;
    bit   slv_err   = 1'b0;
    bit   never_rdy = 1'b0;
    int   acc_n     = 0;
    logic rdy;

    always @(posedge clk) acc_n <= bus.PENABLE ? acc_n + 1 : 0;
    assign rdy = bus.PENABLE && !never_rdy && (acc_n >= slv_wait);

    for (genvar i = 0; i < 4; i++) begin : g_slv
        assign bus.PREADY[i]           = bus.PSEL[i] ? rdy : 1'b1;
        assign bus.PSLVERR[i]          = bus.PSEL[i] ? (rdy & slv_err) : 1'b1;
        assign bus.PRDATA[i*32 +: 32]  = SLV_DATA[i];
    end

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } apb_t;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int unsigned cyc;
        int          acc;
    } resp_t;

    apb_t        exp_apb [$];
    resp_t       exp_resp[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    logic [31:0] last_rd  = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an APB expectation at each SETUP cycle and an AHB expectation each
    // time HREADY rises after a transfer.
    logic  prev_hready = 1'b1;
    logic  prev_hresp  = 1'b0;
    int    mon_acc     = 0;
    apb_t  ma;
    resp_t mr;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hready = 1'b1;
                prev_hresp  = 1'b0;
                mon_acc     = 0;
            end else begin
                if (bus.PENABLE) mon_acc++;
                if ((bus.PSEL != 4'b0) && !bus.PENABLE) begin
                    if (exp_apb.size() == 0) begin
                        check("unexpected APB setup, pending", exp_apb.size(), 1);
                    end else begin
                        ma = exp_apb.pop_front();
                        check("apb psel", bus.PSEL, ma.sel);
                        check("apb paddr", bus.PADDR, ma.addr);
                        check("apb pwrite", bus.PWRITE, ma.wr);
                        check("apb pstrb", bus.PSTRB, ma.strb);
                        if (ma.wr) check("apb pwdata", bus.PWDATA, ma.wdata);
                    end
                end
                if (bus.HREADY && !prev_hready) begin
                    if (exp_resp.size() == 0) begin
                        check("unexpected AHB completion, pending", exp_resp.size(), 1);
                    end else begin
                        mr = exp_resp.pop_front();
                        check("hresp", bus.HRESP, mr.resp);
                        check("hresp in cycle before completion", prev_hresp, mr.resp);
                        check("hrdata", bus.HRDATA, mr.rdata);
                        check("completion cycle", cyc, mr.cyc);
                        check("access cycles", mon_acc, mr.acc);
                        check("psel at completion", bus.PSEL, 0);
                    end
                    mon_acc = 0;
                end
                prev_hready = bus.HREADY;
                prev_hresp  = bus.HRESP;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_resp.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_resp.size() != 0) begin
            check("drain timeout, pending responses", exp_resp.size(), 0);
            exp_resp.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Issue one AHB transfer and queue what it must produce. e_sel = 0 marks a decode error.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                        input logic [31:0] wdata, input int wait_n, input bit err,
                        input bit never, input logic [3:0] e_sel, input logic [3:0] e_strb,
                        input bit e_resp, input int e_acc, input logic [31:0] e_rdata,
                        input bit b2b, output int unsigned k);
        int    n = 0;
        int    lat;
        apb_t  a;
        resp_t r;
        if (!b2b) drain();
        slv_wait   = wait_n;
        slv_err    = err;
        never_rdy  = never;
        bus.HSEL   = 1'b1;
        bus.HADDR  = addr;
        bus.HTRANS = 2'b10;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.HREADY && n < 200);
        if (!bus.HREADY) begin
            check("accept timeout, hready", bus.HREADY, 1);
            bus.HSEL   = 1'b0;
            bus.HTRANS = 2'b00;
            k = 0;
            return;
        end
        @(posedge clk);
        #1;
        k          = cyc;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = wdata;
        if (e_sel != 4'b0) begin
            a.sel = e_sel; a.addr = addr; a.wr = wr; a.strb = e_strb; a.wdata = wdata;
            exp_apb.push_back(a);
            lat = (wr ? 1 : 0) + 1 + e_acc + (e_resp ? 1 : 0);
        end else begin
            lat = 1;
        end
        if (!wr && !e_resp) last_rd = e_rdata;
        r.resp = e_resp; r.rdata = last_rd; r.cyc = k + lat; r.acc = e_acc;
        exp_resp.push_back(r);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " hready"}, bus.HREADY, 1);
        check({tag, " hresp"}, bus.HRESP, 0);
        check({tag, " psel"}, bus.PSEL, 0);
        check({tag, " penable"}, bus.PENABLE, 0);
        check({tag, " pwrite"}, bus.PWRITE, 0);
        check({tag, " pstrb"}, bus.PSTRB, 0);
        check({tag, " paddr"}, bus.PADDR, 0);
        check({tag, " pwdata"}, bus.PWDATA, 0);
        check({tag, " hrdata"}, bus.HRDATA, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench time limit");
    end

    int unsigned k1;
    int unsigned k2;
    int          n;

    initial begin
        rst        = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HADDR  = 32'h0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd0;
        bus.HWDATA = 32'h0;
        #1 rst = 1'b1;
        #1 check_reset_values("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // addr wr size wdata wait err never | sel strb resp acc rdata | b2b
        xfer(32'h0000_2010, 0, 3'd2, 32'h0, 0, 0, 0, 4'b0100, 4'b0000, 0, 1, 32'hCAFE_F00D, 0, k1);
        xfer(32'h0000_1003, 1, 3'd0, 32'hAB00_0000, 0, 0, 0, 4'b0010, 4'b1000, 0, 1, 32'h0, 0, k1);
        xfer(32'h0000_3006, 1, 3'd1, 32'h1234_0000, 0, 0, 0, 4'b1000, 4'b1100, 0, 1, 32'h0, 0, k1);
        xfer(32'h0000_0001, 1, 3'd2, 32'hDEAD_BEEF, 0, 0, 0, 4'b0001, 4'b1111, 0, 1, 32'h0, 0, k1);
        // PSLVERR after three wait states
        xfer(32'h0000_0000, 0, 3'd2, 32'h0, 3, 1, 0, 4'b0001, 4'b0000, 1, 4, 32'h0, 0, k1);
        // watchdog expiry, then ready in the last allowed cycle
        xfer(32'h0000_1000, 0, 3'd2, 32'h0, 0, 0, 1, 4'b0010, 4'b0000, 1, 16, 32'h0, 0, k1);
        xfer(32'h0000_1008, 1, 3'd2, 32'h0F0F_0F0F, 15, 0, 0, 4'b0010, 4'b1111, 0, 16, 32'h0,
             0, k1);
        // decode errors: index out of range, oversize transfer
        xfer(32'h0000_5000, 0, 3'd2, 32'h0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 32'h0, 0, k1);
        xfer(32'h0000_1000, 1, 3'd3, 32'h7777_7777, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 32'h0, 0, k1);

        // BUSY and IDLE transfers are ignored
        drain();
        bus.HSEL  = 1'b1;
        bus.HADDR = 32'h0000_2000;
        for (int c = 0; c < 4; c++) begin
            bus.HTRANS = (c < 2) ? 2'b01 : 2'b00;
            @(negedge clk);
            check("idle/busy hready", bus.HREADY, 1);
            check("idle/busy hresp", bus.HRESP, 0);
            @(posedge clk);
            #1;
        end
        bus.HSEL = 1'b0;

        // back-to-back reads: second address phase accepted in the first one's DONE cycle
        xfer(32'h0000_3000, 0, 3'd2, 32'h0, 0, 0, 0, 4'b1000, 4'b0000, 0, 1, 32'h4444_3333, 0, k1);
        xfer(32'h0000_1004, 0, 3'd2, 32'h0, 0, 0, 0, 4'b0010, 4'b0000, 0, 1, 32'h2222_1111, 1, k2);
        check("back-to-back accept cycle", k2, k1 + 3);

        // reset in the middle of an ACCESS phase
        xfer(32'h0000_2000, 1, 3'd2, 32'h5A5A_5A5A, 5, 0, 0, 4'b0100, 4'b1111, 0, 6, 32'h0, 0, k1);
        n = 0;
        while (!bus.PENABLE && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("penable before mid-transfer reset", bus.PENABLE, 1);
        #2 rst = 1'b1;
        #1 check_reset_values("mid-transfer reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_resp.delete();
        last_rd = 32'h0;

        // bridge comes back cleanly and the aborted access is not resumed
        xfer(32'h0000_0008, 0, 3'd2, 32'h0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 32'h1111_0000, 0, k1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("leftover AHB expectations", exp_resp.size(), 0);
        check("leftover APB expectations", exp_apb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
